// File: rtl/aquila_mem_pkg.sv
// ---------------------------------------------------------------------------
// aquila_mem_pkg
//   Shared types and helpers for the Aquila memory responder:
//     chan_state_t : per-channel request FSM states (IDLE -> WAIT -> RESP)
//     NOP_INSTR    : instruction returned for fetches outside the array window
//     word_index   : byte address to word index relative to a base address
// ---------------------------------------------------------------------------
package aquila_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } chan_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Word index of a byte address. The subtraction wraps, so addresses below
    // the base become huge indices and fall outside any realistic depth.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/aquila_mem_chan_timer.sv
// ---------------------------------------------------------------------------
// aquila_mem_chan_timer
//   Request sequencer for one responder channel. A strobe seen in IDLE or
//   RESP is accepted and completes LAT + extra_i cycles later.
//   Ports:
//     clk_i     in   clock, rising edge
//     rst_i     in   asynchronous reset, active-low
//     strobe_i  in   request pulse
//     extra_i   in   additional wait cycles (0-3) for the request accepted now
//     accept_o  out  the request on strobe_i is taken at this edge
//     fire_o    out  the channel enters RESP at this edge (read/commit now)
//     ready_o   out  one-cycle completion pulse (channel is in RESP)
// ---------------------------------------------------------------------------
module aquila_mem_chan_timer
    import aquila_mem_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       strobe_i,
    input  logic [1:0] extra_i,
    output logic       accept_o,
    output logic       fire_o,
    output logic       ready_o
);

    localparam int unsigned CNT_W = $clog2(LAT + 4) + 1;

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] total;

    assign total = CNT_W'(LAT) + CNT_W'(extra_i);

    // State and countdown registers; reset abandons any request in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RESP behaves like IDLE for acceptance so requests can run back-to-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (strobe_i) begin
                    accept_o = 1'b1;
                    if (total == CNT_W'(1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = total - CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so nothing is read or committed while reset is held.
    assign fire_o  = rst_i && (state_d == RESP);
    assign ready_o = (state_q == RESP);

endmodule

// File: rtl/aquila_mem_responder.sv
// ---------------------------------------------------------------------------
// aquila_mem_responder
//   Deterministic memory model for the Aquila core's instruction and data
//   ports. Fetches, loads and stores are served from an internal word array
//   after a fixed per-channel latency.
//   Ports:
//     clk_i, rst_i                      clock / asynchronous active-low reset
//     p_strobe_i, p_addr_i              fetch request
//     code_o, code_ready_o              fetch response
//     d_strobe_i, d_addr_i, d_rw_i,     load/store request (d_rw_i=1 store)
//     d_byte_enable_i, d_data_i
//     data_o, data_ready_o,             load/store response; data_addr_ext_o
//     data_addr_ext_o                   flags an address outside the array
//   Configuration macro AQUILA_MEM_STALL_INJ_EN: adds 0-3 pseudo-random wait
//   cycles per request from a 16-bit LFSR seeded with LFSR_SEED.
// ---------------------------------------------------------------------------
module aquila_mem_responder
    import aquila_mem_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned     I_LAT     = 1,
    parameter int unsigned     D_LAT     = 2,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            p_strobe_i,
    input  logic [XLEN-1:0] p_addr_i,
    output logic [XLEN-1:0] code_o,
    output logic            code_ready_o,
    input  logic            d_strobe_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic            d_rw_i,
    input  logic [3:0]      d_byte_enable_i,
    input  logic [XLEN-1:0] d_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            data_ready_o,
    output logic            data_addr_ext_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];

    logic [1:0]      extraStall;
    logic            pAccept, pFire, dAccept, dFire;

    logic [XLEN-1:0] pAddr_q, dAddr_q, dWdata_q;
    logic            dRw_q;
    logic [3:0]      dBe_q;
    logic [XLEN-1:0] code_q, data_q;
    logic            ext_q;

    logic [XLEN-1:0] pAddrEff, dAddrEff, dWdataEff;
    logic            dRwEff;
    logic [3:0]      dBeEff;
    logic [31:0]     pIdxFull, dIdxFull;
    logic [IDX_W-1:0] pIdx, dIdx;
    logic            pInRange, dInRange;

`ifdef AQUILA_MEM_STALL_INJ_EN
    logic [15:0] lfsr_q;
    logic        lfsrFb;

    assign lfsrFb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Free-running Fibonacci LFSR (taps 16,14,13,11); sampled on each accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsrFb};
        end
    end

    assign extraStall = lfsr_q[1:0];
`else
    // No stall injection; the seed is masked off so both builds share one parameter list.
    assign extraStall = LFSR_SEED[1:0] & 2'b00;
`endif

    aquila_mem_chan_timer #(.LAT(I_LAT)) uFetchTimer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .strobe_i (p_strobe_i),
        .extra_i  (extraStall),
        .accept_o (pAccept),
        .fire_o   (pFire),
        .ready_o  (code_ready_o)
    );

    aquila_mem_chan_timer #(.LAT(D_LAT)) uDataTimer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .strobe_i (d_strobe_i),
        .extra_i  (extraStall),
        .accept_o (dAccept),
        .fire_o   (dFire),
        .ready_o  (data_ready_o)
    );

    // A single-cycle request fires at the same edge it is accepted, so the
    // live inputs are used then; otherwise the latched copy is used.
    assign pAddrEff  = pAccept ? p_addr_i        : pAddr_q;
    assign dAddrEff  = dAccept ? d_addr_i        : dAddr_q;
    assign dRwEff    = dAccept ? d_rw_i          : dRw_q;
    assign dBeEff    = dAccept ? d_byte_enable_i : dBe_q;
    assign dWdataEff = dAccept ? d_data_i        : dWdata_q;

    assign pIdxFull = word_index(pAddrEff, BASE_ADDR);
    assign dIdxFull = word_index(dAddrEff, BASE_ADDR);
    assign pInRange = (pIdxFull < 32'(DEPTH));
    assign dInRange = (dIdxFull < 32'(DEPTH));
    assign pIdx     = pIdxFull[IDX_W-1:0];
    assign dIdx     = dIdxFull[IDX_W-1:0];

    // Request capture and response registers. Strobes during WAIT never
    // reach here because the timer does not accept them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pAddr_q  <= '0;
            dAddr_q  <= '0;
            dRw_q    <= 1'b0;
            dBe_q    <= '0;
            dWdata_q <= '0;
            code_q   <= '0;
            data_q   <= '0;
            ext_q    <= 1'b0;
        end else begin
            if (pAccept) begin
                pAddr_q <= p_addr_i;
            end
            if (dAccept) begin
                dAddr_q  <= d_addr_i;
                dRw_q    <= d_rw_i;
                dBe_q    <= d_byte_enable_i;
                dWdata_q <= d_data_i;
            end
            if (pFire) begin
                code_q <= pInRange ? mem_q[pIdx] : NOP_INSTR;
            end
            if (dFire) begin
                ext_q <= !dInRange;
                if (!dRwEff) begin
                    data_q <= dInRange ? mem_q[dIdx] : '0;
                end
            end
        end
    end

    // Store commit at the RESP edge; a fetch firing at the same edge reads
    // the old word because both use non-blocking updates.
    always_ff @(posedge clk_i) begin
        if (dFire && dRwEff && dInRange) begin
            for (int k = 0; k < 4; k++) begin
                if (dBeEff[k]) begin
                    mem_q[dIdx][8*k +: 8] <= dWdataEff[8*k +: 8];
                end
            end
        end
    end

    assign code_o          = code_q;
    assign data_o          = data_q;
    assign data_addr_ext_o = ext_q;

endmodule

// File: tb/tb_aquila_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_aquila_mem_responder
//   Scoreboard bench: requests push their expected response (value, address
//   flag, latency window) into per-channel queues; a monitor pops and
//   compares whenever a ready pulse appears. The reference memory is an
//   associative array of words updated with plain byte-lane arithmetic.
// ---------------------------------------------------------------------------
module tb_aquila_mem_responder;

    localparam int          I_LAT = 1;
    localparam int          D_LAT = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef AQUILA_MEM_STALL_INJ_EN
    localparam int EXTRA_MAX = 3;
`else
    localparam int EXTRA_MAX = 0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        pStrobe = 1'b0;
    logic [31:0] pAddr = '0;
    logic [31:0] codeOut;
    logic        codeReady;
    logic        dStrobe = 1'b0;
    logic [31:0] dAddr = '0;
    logic        dRw = 1'b0;
    logic [3:0]  dBe = '0;
    logic [31:0] dData = '0;
    logic [31:0] dataOut;
    logic        dataReady;
    logic        dataExt;

    typedef struct {
        logic [31:0] data;
        logic        ext;
        int          issue;
        int          latMin;
        int          latMax;
    } expect_t;

    expect_t     fetchQ[$];
    expect_t     dataQ[$];
    expect_t     fE, dE;
    logic [31:0] model [int];
    logic [31:0] lastData = '0;
    int          cycleCount = 0;
    int          tests = 0;
    int          failures = 0;

    aquila_mem_responder uDut (
        .clk_i           (clk),
        .rst_i           (rstN),
        .p_strobe_i      (pStrobe),
        .p_addr_i        (pAddr),
        .code_o          (codeOut),
        .code_ready_o    (codeReady),
        .d_strobe_i      (dStrobe),
        .d_addr_i        (dAddr),
        .d_rw_i          (dRw),
        .d_byte_enable_i (dBe),
        .d_data_i        (dData),
        .data_o          (dataOut),
        .data_ready_o    (dataReady),
        .data_addr_ext_o (dataExt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkLatency(input string name, input int lat, input int lo, input int hi);
        tests++;
        if (lat < lo || lat > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d cycles, expected %0d..%0d", name, lat, lo, hi);
        end
    endtask

    function automatic bit inWindow(input logic [31:0] a);
        return (a - BASE) < 32'(DEPTH * 4);
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] readModel(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            r = r + (((be[k] ? (wd >> (8 * k)) : (old >> (8 * k))) & 32'hFF) << (8 * k));
        end
        return r;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (codeReady) begin
            if (fetchQ.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL unexpected code_ready: got 1, expected 0 (code %h)", codeOut);
            end else begin
                fE = fetchQ.pop_front();
                checkOutput("fetch code", codeOut, fE.data);
                checkLatency("fetch latency", cycleCount - fE.issue, fE.latMin, fE.latMax);
            end
        end
        if (dataReady) begin
            if (dataQ.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL unexpected data_ready: got 1, expected 0 (data %h)", dataOut);
            end else begin
                dE = dataQ.pop_front();
                checkOutput("data value", dataOut, dE.data);
                checkOutput("data ext", {31'b0, dataExt}, {31'b0, dE.ext});
                checkLatency("data latency", cycleCount - dE.issue, dE.latMin, dE.latMax);
            end
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 40 && (fetchQ.size() != 0 || dataQ.size() != 0); i++) begin
            @(posedge clk);
        end
        if (fetchQ.size() != 0 || dataQ.size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL response timeout: got %0d/%0d pending, expected 0/0", fetchQ.size(), dataQ.size());
            fetchQ.delete();
            dataQ.delete();
        end
    endtask

    // Pushes the expected data-channel response and updates the model for a store.
    task automatic pushData(input logic rw, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        expect_t e;
        e.issue  = cycleCount;
        e.latMin = D_LAT;
        e.latMax = D_LAT + EXTRA_MAX;
        e.ext    = !inWindow(addr);
        if (rw) begin
            e.data = lastData;
            if (inWindow(addr)) model[wordOf(addr)] = mergeBytes(readModel(wordOf(addr)), wd, be);
        end else begin
            e.data   = inWindow(addr) ? readModel(wordOf(addr)) : 32'h0;
            lastData = e.data;
        end
        dataQ.push_back(e);
    endtask

    task automatic pushFetch(input logic [31:0] addr, input logic [31:0] exp);
        expect_t e;
        e.issue  = cycleCount;
        e.latMin = I_LAT;
        e.latMax = I_LAT + EXTRA_MAX;
        e.ext    = 1'b0;
        e.data   = exp;
        fetchQ.push_back(e);
    endtask

    // kind: 0 fetch, 1 load, 2 store. One request, then wait for its response.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        if (kind == 0) begin
            pushFetch(addr, inWindow(addr) ? readModel(wordOf(addr)) : 32'h0000_0013);
            pStrobe = 1'b1;
            pAddr   = addr;
        end else begin
            pushData(kind == 2, addr, be, wd);
            dStrobe = 1'b1;
            dAddr   = addr;
            dRw     = (kind == 2);
            dBe     = be;
            dData   = wd;
        end
        @(negedge clk);
        pStrobe = 1'b0;
        dStrobe = 1'b0;
        waitIdle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " code_o"}, codeOut, 32'h0);
        checkOutput({tag, " data_o"}, dataOut, 32'h0);
        checkOutput({tag, " readys"}, {30'b0, codeReady, dataReady}, 32'h0);
        checkOutput({tag, " ext"}, {31'b0, dataExt}, 32'h0);
    endtask

    initial begin
        logic [31:0] a, w, oldWord;
        int kind;

        // Reset state, then 20 idle cycles with no responses.
        repeat (3) @(negedge clk);
        checkResetOutputs("in reset");
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        checkResetOutputs("idle");

        // Known contents for words 0..15 and the last word.
        for (int i = 0; i < 16; i++) applyStimulus(2, 32'(i * 4), 4'b1111, $urandom);
        applyStimulus(2, 32'(DEPTH * 4 - 4), 4'b1111, $urandom);

        // Fetch of a freshly stored word.
        applyStimulus(2, 32'h10, 4'b1111, 32'hDEAD_BEEF);
        applyStimulus(0, 32'h10, 4'b0000, 32'h0);

        // Partial byte-lane store over zero.
        applyStimulus(2, 32'h20, 4'b1111, 32'h0);
        applyStimulus(2, 32'h20, 4'b0101, 32'h1122_3344);
        applyStimulus(1, 32'h20, 4'b0000, 32'h0);

        // Window boundaries and misaligned low bits.
        applyStimulus(1, 32'h0000_1000, 4'b0000, 32'h0);
        applyStimulus(0, 32'h0000_1000, 4'b0000, 32'h0);
        applyStimulus(2, 32'h0000_1000, 4'b1111, 32'hCAFE_F00D);
        applyStimulus(1, 32'h0000_0FFC, 4'b0000, 32'h0);
        applyStimulus(2, 32'h0000_0FFE, 4'b1000, 32'hA500_0000);
        applyStimulus(1, 32'h0000_0FFF, 4'b0000, 32'h0);

`ifndef AQUILA_MEM_STALL_INJ_EN
        // Store commit and fetch response at the same edge: fetch sees old word.
        oldWord = readModel(8);
        w = $urandom;
        @(negedge clk);
        pushData(1'b1, 32'h20, 4'b1111, w);
        dStrobe = 1'b1; dAddr = 32'h20; dRw = 1'b1; dBe = 4'b1111; dData = w;
        @(negedge clk);
        dStrobe = 1'b0;
        pushFetch(32'h20, oldWord);
        pStrobe = 1'b1; pAddr = 32'h20;
        @(negedge clk);
        pStrobe = 1'b0;
        waitIdle();
        applyStimulus(0, 32'h20, 4'b0000, 32'h0);
`endif

        // Reset during WAIT of a store cancels it.
        oldWord = readModel(9);
        @(negedge clk);
        dStrobe = 1'b1; dAddr = 32'h24; dRw = 1'b1; dBe = 4'b1111; dData = ~oldWord;
        @(negedge clk);
        dStrobe = 1'b0;
        rstN = 1'b0;
        lastData = 32'h0;
        repeat (2) @(negedge clk);
        checkResetOutputs("mid reset");
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        checkResetOutputs("after reset");
        applyStimulus(1, 32'h24, 4'b0000, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(2, 0);
            if ($urandom_range(7, 0) == 0) a = $urandom | 32'h0000_1000;
            else a = 32'($urandom_range(15, 0) * 4 + $urandom_range(3, 0));
            applyStimulus(kind, a, 4'($urandom), $urandom);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global timeout: got no end of test, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
